// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared FSM state encoding and synchronizer depth for the SPI target.
package spi_target_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous pin with rise/fall pulses.
//   clk, n_rst : system clock, asynchronous active-low reset
//   d          : asynchronous input pin
//   q          : synchronized level
//   rise, fall : one-cycle pulses when q changes 0->1 / 1->0
module spi_sync_edge
    import spi_target_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  prev;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync <= {SYNC_DEPTH{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], d};
            prev <= sync[SYNC_DEPTH-1];
        end
    end

    always_comb begin
        q    = sync[SYNC_DEPTH-1];
        rise = q & ~prev;
        fall = ~q & prev;
    end

endmodule

// File: rtl/spi_target.sv
// spi_target: oversampled SPI target shifting DATA_W-bit words with a one-entry transmit holding register.
//   clk, n_rst         : system clock, asynchronous active-low reset
//   sclk, cs_n, mosi   : SPI pins from the controller (asynchronous)
//   miso, miso_oe      : serial data out and its output enable
//   tx_data/valid/ready: holding-register write handshake
//   rx_data, rx_valid  : last received word and its one-cycle update pulse
//   underrun           : one-cycle pulse when a word load found the holding register empty
module spi_target
    import spi_target_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun
);

    localparam int            CW        = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST      = CW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL      = CW'(DATA_W);
    localparam logic          IDLE_LVL  = (CPOL != 0);
    localparam logic          LATE_LOAD = (CPHA != 0);

    state_t                state, state_nx;
    logic                  sclk_q, sclk_rise, sclk_fall;
    logic                  cs_q, cs_rise, cs_fall;
    logic [SYNC_DEPTH-1:0] mosi_sync;
    logic                  mosi_s;
    logic [CW-1:0]         cnt;
    logic [DATA_W-1:0]     tx_sr, tx_adv, rx_sr, rx_next, hold_data;
    logic                  hold_full;
    logic                  lead, trail, sample_e, shift_e;
    logic                  do_load, do_sample, do_shift, word_done;

    spi_sync_edge #(.RST_VAL(IDLE_LVL)) u_sclk (
        .clk  (clk),
        .n_rst(n_rst),
        .d    (sclk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk  (clk),
        .n_rst(n_rst),
        .d    (cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // An edge that moves sclk away from its idle level is the leading edge.
    always_comb begin
        mosi_s   = mosi_sync[SYNC_DEPTH-1];
        lead     = (sclk_rise | sclk_fall) & (sclk_q != IDLE_LVL);
        trail    = (sclk_rise | sclk_fall) & (sclk_q == IDLE_LVL);
        sample_e = LATE_LOAD ? trail : lead;
        shift_e  = LATE_LOAD ? lead : trail;
        rx_next  = (MSB_FIRST != 0) ? {rx_sr[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr[DATA_W-1:1]};
        tx_adv   = (MSB_FIRST != 0) ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cs_fall ? LOAD : IDLE;
            LOAD:    state_nx = cs_rise ? IDLE : SHIFT;
            SHIFT:   state_nx = cs_rise ? IDLE : (word_done & ~LATE_LOAD) ? LOAD : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    // A shift edge with the counter at 0 follows a fresh load and must not
    // advance past the first bit; with CPHA=1 a full counter on the shift
    // edge reloads instead, so that edge presents the next word's first bit.
    always_comb begin
        do_load   = ~cs_rise & ((state == LOAD) | ((state == SHIFT) & LATE_LOAD & shift_e & (cnt == FULL)));
        do_sample = ~cs_rise & (state == SHIFT) & sample_e;
        do_shift  = ~cs_rise & (state == SHIFT) & shift_e & (cnt != '0) & (cnt != FULL);
        word_done = do_sample & (cnt == LAST);
        miso      = (state == IDLE) ? 1'b0 : (MSB_FIRST != 0) ? tx_sr[DATA_W-1] : tx_sr[0];
        miso_oe   = ~cs_q;
        tx_ready  = ~hold_full;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mosi_sync <= '0;
            cnt       <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], mosi};
            cnt       <= ((state == IDLE) | cs_rise | do_load) ? '0 : do_sample ? cnt + 1'b1 : cnt;
            tx_sr     <= do_load ? (hold_full ? hold_data : '0) : do_shift ? tx_adv : tx_sr;
            rx_sr     <= do_sample ? rx_next : rx_sr;
            rx_data   <= word_done ? rx_next : rx_data;
            rx_valid  <= word_done;
            underrun  <= do_load & ~hold_full;
            // A write landing in the same cycle as an empty load stays held for the next load.
            hold_full <= (do_load & hold_full) ? 1'b0 : (tx_valid & ~hold_full) ? 1'b1 : hold_full;
            hold_data <= (tx_valid & ~hold_full) ? tx_data : hold_data;
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target in mode 0 MSB-first and mode 3 LSB-first.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       n_rst, sclk, cs_n, mosi, tx_valid, sel;
    logic [7:0] tx_data;
    logic       cs_n0, cs_n3, tv0, tv3;
    logic       miso0, oe0, rdy0, rv0, ur0;
    logic       miso3, oe3, rdy3, rv3, ur3;
    logic [7:0] rx0, rx3;
    logic       miso_m, rdy_m, rv_m, ur_m;
    logic [7:0] rx_m;

    int         tests = 0;
    int         fails = 0;
    int         und   = 0;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    assign cs_n0  = sel ? 1'b1 : cs_n;
    assign cs_n3  = sel ? cs_n : 1'b1;
    assign tv0    = tx_valid & ~sel;
    assign tv3    = tx_valid & sel;
    assign miso_m = sel ? miso3 : miso0;
    assign rdy_m  = sel ? rdy3 : rdy0;
    assign rv_m   = sel ? rv3 : rv0;
    assign ur_m   = sel ? ur3 : ur0;
    assign rx_m   = sel ? rx3 : rx0;

    spi_target #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
        .clk(clk), .n_rst(n_rst), .sclk(sclk), .cs_n(cs_n0), .mosi(mosi),
        .miso(miso0), .miso_oe(oe0), .tx_data(tx_data), .tx_valid(tv0),
        .tx_ready(rdy0), .rx_data(rx0), .rx_valid(rv0), .underrun(ur0)
    );

    spi_target #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u3 (
        .clk(clk), .n_rst(n_rst), .sclk(sclk), .cs_n(cs_n3), .mosi(mosi),
        .miso(miso3), .miso_oe(oe3), .tx_data(tx_data), .tx_valid(tv3),
        .tx_ready(rdy3), .rx_data(rx3), .rx_valid(rv3), .underrun(ur3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Every received word must match the next word the controller finished sending.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (ur_m) und++;
                if (rv_m) begin
                    if (rxq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx_valid_unexpected: got pulse with rx_data 0x%0h, expected no pulse", rx_m);
                    end else begin
                        chk("rx_data_stream", {24'h0, rx_m}, {24'h0, rxq.pop_front()});
                    end
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_hold(input logic [7:0] d);
        int w = 0;
        while (!rdy_m && w < 50) begin
            tick(1);
            w++;
        end
        chk("tx_ready_wait", {31'h0, rdy_m}, 32'h1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Controller side: 6 clk per sclk phase; mode 0 MSB-first, mode 3 LSB-first.
    task automatic send_word(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int k;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            k    = sel ? i : 7 - i;
            sclk = 1'b0;
            mosi = mo[k];
            tick(6);
            mi[k] = miso_m;
            sclk  = 1'b1;
            tick(6);
        end
        sclk = sel;
        tick(6);
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;
        int         u;
        n_rst = 1'b0; sel = 1'b0; sclk = 1'b0; cs_n = 1'b1;
        mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        fork
            monitor();
        join_none
        tick(4);
        chk("rst_miso", {31'h0, miso0}, 0);
        chk("rst_miso_oe", {31'h0, oe0}, 0);
        chk("rst_tx_ready", {31'h0, rdy0}, 1);
        chk("rst_rx_data", {24'h0, rx0}, 0);
        chk("rst_rx_valid", {31'h0, rv0}, 0);
        chk("rst_underrun", {31'h0, ur0}, 0);
        chk("rst_tx_ready_m3", {31'h0, rdy3}, 1);
        n_rst = 1'b1;
        tick(4);

        write_hold(8'hA5);
        frame_start();
        chk("t1_miso_oe", {31'h0, oe0}, 1);
        chk("t1_tx_ready_after_load", {31'h0, rdy_m}, 1);
        rxq.push_back(8'h3C);
        send_word(8'h3C, 8, mi);
        chk("t1_miso_word", {24'h0, mi}, 32'hA5);
        frame_end();
        chk("t1_rx_data", {24'h0, rx_m}, 32'h3C);
        chk("t1_rx_drained", rxq.size(), 0);

        write_hold(8'h66);
        frame_start();
        send_word(8'hFF, 5, mi);
        chk("t4_miso_partial", {24'h0, mi}, 32'h60);
        frame_end();
        chk("t4_rx_kept", {24'h0, rx_m}, 32'h3C);
        write_hold(8'h99);
        frame_start();
        rxq.push_back(8'hC3);
        send_word(8'hC3, 8, mi);
        chk("t4_next_miso", {24'h0, mi}, 32'h99);
        frame_end();
        chk("t4_next_rx", {24'h0, rx_m}, 32'hC3);

        chk("t5_ready_before", {31'h0, rdy_m}, 1);
        u = und;
        @(posedge clk);
        #1 cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 tx_data = 8'hE7;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(5);
        chk("t5_underrun", und - u, 1);
        chk("t5_ready_held", {31'h0, rdy_m}, 0);
        rxq.push_back(8'h0F);
        rxq.push_back(8'hF0);
        send_word(8'h0F, 8, mi);
        chk("t5_miso_zero", {24'h0, mi}, 32'h00);
        chk("t5_second_load_ok", und - u, 1);
        send_word(8'hF0, 8, mi);
        chk("t5_miso_new", {24'h0, mi}, 32'hE7);
        frame_end();
        chk("t5_rx", {24'h0, rx_m}, 32'hF0);

        write_hold(8'h11);
        frame_start();
        write_hold(8'h22);
        send_word(8'hAA, 3, mi);
        n_rst = 1'b0;
        #1;
        chk("r_miso", {31'h0, miso0}, 0);
        chk("r_miso_oe", {31'h0, oe0}, 0);
        chk("r_tx_ready", {31'h0, rdy0}, 1);
        chk("r_rx_data", {24'h0, rx0}, 0);
        chk("r_rx_valid", {31'h0, rv0}, 0);
        chk("r_underrun", {31'h0, ur0}, 0);
        rxq.delete();
        cs_n = 1'b1;
        tick(3);
        n_rst = 1'b1;
        tick(4);
        chk("r_ready_after", {31'h0, rdy0}, 1);
        write_hold(8'h33);
        frame_start();
        rxq.push_back(8'h96);
        send_word(8'h96, 8, mi);
        chk("r_next_miso", {24'h0, mi}, 32'h33);
        frame_end();
        chk("r_next_rx", {24'h0, rx_m}, 32'h96);

        sel  = 1'b1;
        sclk = 1'b1;
        tick(8);
        u = und;
        write_hold(8'h35);
        frame_start();
        chk("m3_miso_oe", {31'h0, oe3}, 1);
        rxq.push_back(8'h81);
        send_word(8'h81, 8, mi);
        chk("m3_miso_w0", {24'h0, mi}, 32'h35);
        write_hold(8'hC6);
        rxq.push_back(8'h7E);
        send_word(8'h7E, 8, mi);
        chk("m3_miso_w1", {24'h0, mi}, 32'hC6);
        frame_end();
        chk("m3_no_underrun", und - u, 0);
        chk("m3_rx", {24'h0, rx_m}, 32'h7E);

        chk("m3u_ready", {31'h0, rdy_m}, 1);
        u = und;
        frame_start();
        rxq.push_back(8'h1D);
        send_word(8'h1D, 8, mi);
        chk("m3u_miso_zero", {24'h0, mi}, 32'h00);
        frame_end();
        chk("m3u_underrun_once", und - u, 1);
        chk("m3u_rx", {24'h0, rx_m}, 32'h1D);
        chk("final_rx_drained", rxq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral-side) serial interface: receives SCLK, CS_N and MOSI from an external SPI controller and drives MISO. All serial inputs are oversampled in the system clock domain. It shifts DATA_W-bit words in both directions simultaneously and hands received words to the bus side. Transmit words come from a one-entry holding register with a valid/ready handshake. It is the responder counterpart of the controller-side shift path in the SPI peripheral.

## Interface
- DATA_W, 8, word length in bits (>= 2)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge
- MSB_FIRST, 1, 1: MSB first on both MOSI and MISO; 0: LSB first

Ports:
- clk  in  1  system clock; the only clock.
- n_rst  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active-low, asynchronous
- mosi  in  1  serial data in
- miso  out  1  serial data out
- miso_oe  out  1  MISO output enable, high while the synchronized cs_n is low
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty
- rx_data  out  DATA_W  last complete received word; held until the next word completes
- rx_valid  out  1  one-cycle pulse when rx_data updates
- underrun  out  1  one-cycle pulse: a word load found the holding register empty

## Operation
- Synchronizers:
  - sclk, cs_n and mosi each pass through a 2-flop synchronizer.
  - A third register on sclk and cs_n provides edge detection.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: waits for synchronized cs_n to fall, then goes to LOAD.
  - LOAD (one cycle): copies the holding register into the shift register and sets the bit counter to 0.
    - If the holding register is empty, loads all-zeros and pulses underrun.
    - If the holding register is full, marks it empty.
    - Then goes to SHIFT.
  - SHIFT, sample edge: captures mosi into the receive shift register and increments the bit counter.
  - SHIFT, shift edge: advances the transmit shift register.
  - SHIFT, word complete (counter reaches DATA_W after a sample):
    - rx_data <= receive shift register; pulse rx_valid.
    - CPHA=0: go to LOAD.
    - CPHA=1: load at the next leading edge, before that edge's shift.
- MISO:
  - Drives the current output bit (MSB or LSB of the shift register, per MSB_FIRST).
  - With CPHA=0, the first bit is valid from LOAD.
  - Drives 0 in IDLE.
- tx_ready = holding register empty. A transfer occurs when tx_valid && tx_ready.
- No receive back-pressure; an unread rx_data is overwritten.

## Timing
- Reset values: miso 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, underrun 0, FSM in IDLE, holding register empty.
- Pin edge to internal edge pulse: 2–3 clk.
- rx_valid asserts 1 clk after the internal pulse for the final sample edge.
- miso changes 1 clk after the internal shift-edge pulse.
- Required sclk period >= 10 clk, with each phase >= 5 clk.
- cs_n setup to the first SCLK edge: >= 4 clk.
- Simultaneous events:
  - Holding register write in the same cycle as LOAD: LOAD sees empty, so underrun fires and zeros are sent. The written word stays held for the next load.
  - Sample and cs_n rise in the same cycle: cs_n wins.
- cs_n rises mid-word:
  - Partial word discarded; no rx_valid.
  - Bit counter cleared; go to IDLE.
  - Holding register unchanged.
- n_rst asserted mid-frame: everything returns to reset values immediately, including discarding the holding register contents.

## Structure
- Package spi_target_pkg: FSM state enum (IDLE, LOAD, SHIFT), synchronizer depth constant (2).
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall pulse outputs, instantiated for sclk and cs_n.
- mosi uses a bare synchronizer of equal depth so it stays aligned with sclk.
- Counter width: $clog2(DATA_W+1).

## Test plan
- Mode 0, DATA_W=8, holding=0xA5; controller sends 0x3C MSB-first at sclk = 12 clk → MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse; tx_ready returns high at LOAD.
- Mode 3 (CPOL=1, CPHA=1), LSB-first, two back-to-back words 0x81, 0x7E, with the holding register refilled between them → both received, both transmitted, no underrun.
- Holding register empty at cs_n fall → underrun pulses once; MISO all zeros; rx still captured.
- cs_n raised after 5 bits → no rx_valid; the next full frame receives correctly, with the counter restarting at 0.
- tx_valid asserted exactly in the LOAD cycle → underrun fires, zeros are sent; the next word transmits the new value.
- n_rst pulsed mid-frame → all outputs at reset values within 1 clk; tx_ready=1; the following frame is correct.
